// File: rtl/hdmi_pixel_align_if.sv
// Pixel-side signal bundle between timing generator / frame buffer and the
// alignment stage; slave is the aligner, master is whoever drives it.
interface hdmi_pixel_align_if;
  logic        I_pattern_en;
  logic        I_vs;
  logic        I_hs;
  logic        I_de;
  logic        I_den;
  logic [15:0] I_data;
  logic        O_vs;
  logic        O_hs;
  logic        O_de;
  logic [7:0]  O_r;
  logic [7:0]  O_g;
  logic [7:0]  O_b;
  logic [15:0] O_underflow_cnt;
  logic        O_frame_err;

  modport master (
    output I_pattern_en, I_vs, I_hs, I_de, I_den, I_data,
    input  O_vs, O_hs, O_de, O_r, O_g, O_b, O_underflow_cnt, O_frame_err
  );

  modport slave (
    input  I_pattern_en, I_vs, I_hs, I_de, I_den, I_data,
    output O_vs, O_hs, O_de, O_r, O_g, O_b, O_underflow_cnt, O_frame_err
  );
endinterface

// File: rtl/hdmi_pixel_align.sv
// Aligns VS/HS/DE to frame-buffer read latency, expands RGB565 to RGB888,
// fills underflowed pixels, optional colour bars, per-frame underflow stats.
module hdmi_pixel_align #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BAR_W      = 160,
  parameter logic [23:0] FILL_RGB   = 24'hFF00FF
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  hdmi_pixel_align_if.slave bus
);

  localparam int unsigned XW = 11;
  localparam int unsigned CW = 16;
  localparam logic [XW-1:0] X_MAX   = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [RD_LATENCY-1:0] vs_dly_q, vs_dly_d;
  logic [RD_LATENCY-1:0] hs_dly_q, hs_dly_d;
  logic [RD_LATENCY-1:0] de_dly_q, de_dly_d;

  logic          vs_o_q, hs_o_q, de_o_q;
  logic [23:0]   rgb_q, rgb_d;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] uf_acc_q, uf_acc_d;
  logic [CW-1:0] uf_cnt_q, uf_cnt_d;
  logic          err_acc_q, err_acc_d;
  logic          frame_err_q, frame_err_d;
  logic          pat_sel_q, pat_sel_d;

  logic          vs_tap, hs_tap, de_tap;
  logic          boundary, underflow, spurious;
  logic [2:0]    bar_idx;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Sync delay line; bit k-1 holds the input delayed by k cycles
  always_comb begin
    vs_dly_d    = vs_dly_q;
    hs_dly_d    = hs_dly_q;
    de_dly_d    = de_dly_q;
    vs_dly_d[0] = bus.I_vs;
    hs_dly_d[0] = bus.I_hs;
    de_dly_d[0] = bus.I_de;
    for (int k = 1; k < int'(RD_LATENCY); k++) begin
      vs_dly_d[k] = vs_dly_q[k-1];
      hs_dly_d[k] = hs_dly_q[k-1];
      de_dly_d[k] = de_dly_q[k-1];
    end
  end

  assign vs_tap = vs_dly_q[RD_LATENCY-1];
  assign hs_tap = hs_dly_q[RD_LATENCY-1];
  assign de_tap = de_dly_q[RD_LATENCY-1];

  // vs_o_q is the tap's value one cycle earlier
  assign boundary  = vs_tap & ~vs_o_q;
  assign underflow = de_tap & ~pat_sel_q & ~bus.I_den;
  assign spurious  = ~de_tap & ~pat_sel_q & bus.I_den;

  // Bar index: number of bar edges at or left of x, which clamps to 7
  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x_q) >= i * BAR_W) bar_idx = 3'(i);
    end
  end

  always_comb begin
    rgb_d       = '0;
    x_d         = '0;
    uf_acc_d    = uf_acc_q;
    uf_cnt_d    = uf_cnt_q;
    err_acc_d   = err_acc_q | spurious;
    frame_err_d = frame_err_q;
    pat_sel_d   = pat_sel_q;

    if (de_tap) begin
      x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
      if (pat_sel_q)      rgb_d = bar_colour(bar_idx);
      else if (bus.I_den) rgb_d = rgb565_to_888(bus.I_data);
      else                rgb_d = FILL_RGB;
    end

    if (underflow && uf_acc_q != CNT_MAX) uf_acc_d = uf_acc_q + CW'(1);

    // Publish the closing frame; this cycle's events belong to the new one
    if (boundary) begin
      uf_cnt_d    = uf_acc_q;
      frame_err_d = err_acc_q | (uf_acc_q != '0);
      uf_acc_d    = CW'(underflow);
      err_acc_d   = spurious;
      pat_sel_d   = bus.I_pattern_en;
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_dly_q    <= '0;
      hs_dly_q    <= '0;
      de_dly_q    <= '0;
      vs_o_q      <= 1'b0;
      hs_o_q      <= 1'b0;
      de_o_q      <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      uf_acc_q    <= '0;
      uf_cnt_q    <= '0;
      err_acc_q   <= 1'b0;
      frame_err_q <= 1'b0;
      pat_sel_q   <= 1'b0;
    end else begin
      vs_dly_q    <= vs_dly_d;
      hs_dly_q    <= hs_dly_d;
      de_dly_q    <= de_dly_d;
      vs_o_q      <= vs_tap;
      hs_o_q      <= hs_tap;
      de_o_q      <= de_tap;
      rgb_q       <= rgb_d;
      x_q         <= x_d;
      uf_acc_q    <= uf_acc_d;
      uf_cnt_q    <= uf_cnt_d;
      err_acc_q   <= err_acc_d;
      frame_err_q <= frame_err_d;
      pat_sel_q   <= pat_sel_d;
    end
  end

  assign bus.O_vs            = vs_o_q;
  assign bus.O_hs            = hs_o_q;
  assign bus.O_de            = de_o_q;
  assign bus.O_r             = rgb_q[23:16];
  assign bus.O_g             = rgb_q[15:8];
  assign bus.O_b             = rgb_q[7:0];
  assign bus.O_underflow_cnt = uf_cnt_q;
  assign bus.O_frame_err     = frame_err_q;

endmodule
